// File: rtl/lfsr_rr_scheduler.sv
// rtl/lfsr_rr_scheduler.sv - shared Galois LFSR message source, round-robin granted to NREQ consumers
module lfsr_rr_scheduler #(
    parameter int N     = 32,
    parameter int NREQ  = 4,
    parameter int CNT_W = 34
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             pause_i,
    input  logic [N-1:0]     seed_i,
    input  logic [N-1:0]     polynomial_i,
    input  logic [CNT_W-1:0] limit_i,
    input  logic [NREQ-1:0]  req_i,
    output logic [NREQ-1:0]  grant_o,
    output logic [N-1:0]     msg_o,
    output logic             msg_valid_o,
    output logic [CNT_W-1:0] issued_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [N-1:0]       lfsr_q, lfsr_d;
    logic [N-1:0]       poly_q, poly_d;
    logic [CNT_W-1:0]   limit_q, limit_d;
    logic [CNT_W-1:0]   issued_q, issued_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [NREQ-1:0]    grant_q, grant_d;
    logic [N-1:0]       msg_q, msg_d;
    logic               valid_q, valid_d;

    logic               found;
    logic [PTR_W-1:0]   win;
    logic [CNT_W-1:0]   issued_inc;
    logic [N-1:0]       lfsr_next;

    // First requester at or after ptr_q, wrapping at NREQ.
    always_comb begin : rr_search
        int k;
        found = 1'b0;
        win   = '0;
        k     = 0;
        for (int i = 0; i < NREQ; i++) begin
            k = int'(ptr_q) + i;
            if (k >= NREQ) k = k - NREQ;
            if (!found && req_i[PTR_W'(k)]) begin
                found = 1'b1;
                win   = PTR_W'(k);
            end
        end
    end

    assign issued_inc = issued_q + CNT_W'(1);
    assign lfsr_next  = {1'b0, lfsr_q[N-1:1]} ^ (lfsr_q[0] ? poly_q : '0);

    always_comb begin
        state_d  = state_q;
        lfsr_d   = lfsr_q;
        poly_d   = poly_q;
        limit_d  = limit_q;
        issued_d = issued_q;
        ptr_d    = ptr_q;
        grant_d  = '0;
        msg_d    = msg_q;
        valid_d  = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    lfsr_d   = seed_i;
                    poly_d   = polynomial_i;
                    limit_d  = limit_i;
                    issued_d = '0;
                    ptr_d    = '0;
                    state_d  = (limit_i == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (!pause_i && found) begin
                    grant_d  = NREQ'(1) << win;
                    msg_d    = lfsr_q;
                    valid_d  = 1'b1;
                    issued_d = issued_inc;
                    lfsr_d   = lfsr_next;
                    ptr_d    = (win == PTR_W'(NREQ - 1)) ? '0 : win + PTR_W'(1);
                    if (issued_inc == limit_q) state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            lfsr_q   <= '0;
            poly_q   <= '0;
            limit_q  <= '0;
            issued_q <= '0;
            ptr_q    <= '0;
            grant_q  <= '0;
            msg_q    <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            poly_q   <= poly_d;
            limit_q  <= limit_d;
            issued_q <= issued_d;
            ptr_q    <= ptr_d;
            grant_q  <= grant_d;
            msg_q    <= msg_d;
            valid_q  <= valid_d;
        end
    end

    assign grant_o     = grant_q;
    assign msg_o       = msg_q;
    assign msg_valid_o = valid_q;
    assign issued_o    = issued_q;
    assign busy_o      = (state_q == S_RUN);
    assign done_o      = (state_q == S_DONE);

endmodule

// File: doc/lfsr_rr_scheduler.md
# lfsr_rr_scheduler

Shares one Galois LFSR message generator between NREQ downstream consumers (DES encryption cores) and sequences a complete run. After `start` it loads the seed, then hands out consecutive LFSR states one per cycle, round-robin among requesters. It stops after a programmed number of messages and reports completion. It replaces per-core free-running generators, so every message of a run is issued exactly once across all cores.

## Interface
- N, 32, LFSR and message width
- NREQ, 4, number of requesters (2..16)
- CNT_W, 34, width of message limit and issue counter

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  single-cycle pulse; samples `seed`, `polynomial` and `limit`
- pause  in  1  level; while high no grant is issued and LFSR/counter hold
- seed  in  N  initial LFSR state
- polynomial  in  N  Galois feedback mask
- limit  in  CNT_W  number of messages in the run
- req  in  NREQ  per-consumer request level; a consumer keeps its bit high while it wants messages
- grant  out  NREQ  registered one-hot; the consumer that owns `msg` this cycle
- msg  out  N  registered message value
- msg_valid  out  1  registered; high exactly in cycles where `grant` is non-zero
- issued  out  CNT_W  messages issued in the current run
- busy  out  1  high in RUN
- done  out  1  high in DONE

## Operation
- States: IDLE, RUN, DONE. After reset the block is in IDLE.
- Reset values: grant=0, msg=0, msg_valid=0, issued=0, busy=0, done=0. Internal LFSR=0 and round-robin pointer=0.
- IDLE or DONE, `start`=1:
  - LFSR is loaded with `seed`; polynomial and limit are latched; issued=0; pointer=0; done=0.
  - If limit==0, go to DONE. Otherwise go to RUN.
- RUN, `start`: ignored. The latched config is not affected by input changes.
- RUN, `pause`=0 and |req:
  - Winner = first set bit of `req`, searching from index `pointer` upward with wrap at NREQ.
  - grant=onehot(winner), msg=current LFSR, msg_valid=1, issued=issued+1.
  - LFSR steps: next = (lfsr>>1) ^ (lfsr[0] ? polynomial : 0).
  - pointer = (winner+1) mod NREQ.
- RUN, `pause`=1 or req==0: grant=0, msg_valid=0. LFSR, issued and pointer hold. `msg` holds its last value.
- Completion: when an issue makes issued==limit, the next state is DONE. busy drops and done rises on that same edge, i.e. together with the final msg_valid.
- DONE: no grants; issued holds the final count. done stays high until the next `start` or `rst`.
- Arithmetic:
  - issued is unsigned CNT_W and never exceeds limit.
  - No wrap-around or period detection. The LFSR may revisit states if limit exceeds the polynomial's period.
  - seed==0 is legal and yields all-zero messages.
- Fairness: with all requesters high, each consumer is granted once per NREQ cycles. A lone requester is granted every cycle.

## Timing
- `start` sampled at edge t: busy=1 after t. `req` is first sampled at edge t+1, so the first grant/msg_valid is visible after t+1.
- `req` sampled at edge e is answered by grant/msg/msg_valid visible in the cycle after e (1-cycle latency). Sustained throughput is 1 message per cycle.
- Consumers capture `msg` on the edge ending the cycle in which their `grant` bit is high. There is no back-pressure beyond dropping `req`.
- A consumer that drops `req` at edge e is never granted from that edge onward.
- `pause` sampled high at edge e suppresses the grant for edge e, with no lag.
- `rst` asserted mid-run clears all outputs asynchronously. No further grants occur; the run is lost and a new `start` is required.
- `start` and `pause` high together in IDLE: the config loads, and the first grant waits for pause=0.

## Test plan
- Single requester: req=0001, seed=0x00000001, polynomial=0xA3000000, limit=3. Expect msg 0x00000001, 0xA3000000, 0x51800000 on three consecutive cycles, grant=0001 each time, done rising with the third, issued=3.
- All requesters high, limit=8. Expect grant sequence 0001, 0010, 0100, 1000, 0001, 0010, 0100, 1000; msg consecutive LFSR states; done with the 8th.
- req=1010 then req=0110 mid-run. Expect the pointer to resume after the last winner; no consumer granted twice while another eligible consumer waits.
- pause high for 5 cycles after 2 issues, limit=6. Expect no msg_valid and issued=2 frozen; the sequence continues from the 3rd LFSR state afterwards; done with the 6th.
- limit=0 start. Expect DONE after one edge, no grant ever, issued=0. `start` during RUN is ignored.
- rst pulse after 4 of 10 messages. Expect all outputs 0 immediately. Then start with seed=0x00000005, limit=2: first msg=0x00000005, second=0xA3000002.
